// File: rtl/spi_sensor_responder.sv
// SPI mode-3 accelerometer responder: 64x8 register file, coherent X/Y snapshot read window; SPI_RSP_DEVID_EN makes address 0 a read-only DEVID.
// Latency: 3 ispi_clk cycles from pin edge to action; no backpressure, the initiator owns the pace.
module spi_sensor_responder #(
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] DATA_BASE = 6'h32
`ifdef SPI_RSP_DEVID_EN
  ,
  parameter logic [7:0]        DEVID     = 8'hE5
`endif
) (
  input  logic              ispi_clk,
  input  logic              ireset,
  input  logic              iSPI_CLK,
  input  logic              iSPI_CSN,
  input  logic              iSPI_SDI,
  output logic              oSPI_SDO,
  input  logic [15:0]       iDATA_X,
  input  logic [15:0]       iDATA_Y,
  input  logic              iDATA_VALID,
  output logic              oREG_WR,
  output logic [ADDR_W-1:0] oREG_ADDR,
  output logic [7:0]        oREG_WDATA,
  output logic              oFRAME_END,
  output logic              oBUSY
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WR_DATA, S_WR_IGNORE, S_RD_DATA} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic                r_csn_s1, r_csn_s2, r_csn_s3;
  logic                r_sdi_s1, r_sdi_s2;
  logic [6:0]          r_shift;
  logic [7:0]          r_tx;
  logic [2:0]          r_bitcnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_sdo;
  logic [15:0]         r_snap_x, r_snap_y;
  logic [7:0]          r_regs [2**ADDR_W];
  logic                r_reg_wr, r_frame_end;
  logic [ADDR_W-1:0]   r_reg_addr;
  logic [7:0]          r_reg_wdata;

  logic                w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall, w_byte_done;
  logic [7:0]          w_shift_next, w_rd_byte;
  logic [ADDR_W-1:0]   w_win_off;
  logic                w_in_win, w_wr_ok;

  // SCLK edges only count while synchronized CSN is low
  assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_s3 & ~r_csn_s2;
  assign w_sclk_fall  = ~r_sclk_s2 & r_sclk_s3 & ~r_csn_s2;
  assign w_csn_rise   = r_csn_s2 & ~r_csn_s3;
  assign w_csn_fall   = ~r_csn_s2 & r_csn_s3;
  assign w_shift_next = {r_shift, r_sdi_s2};
  assign w_byte_done  = w_sclk_rise && (r_bitcnt == 3'd0);
  assign w_win_off    = r_addr - DATA_BASE;
  assign w_in_win     = (w_win_off[ADDR_W-1:2] == '0);

  always_comb begin
    w_rd_byte = r_regs[r_addr];
    w_wr_ok   = ~w_in_win;
    if (w_in_win) begin
      case (w_win_off[1:0])
        2'd0:    w_rd_byte = r_snap_x[7:0];
        2'd1:    w_rd_byte = r_snap_x[15:8];
        2'd2:    w_rd_byte = r_snap_y[7:0];
        default: w_rd_byte = r_snap_y[15:8];
      endcase
    end
`ifdef SPI_RSP_DEVID_EN
    else if (r_addr == '0) begin
      w_rd_byte = DEVID;
      w_wr_ok   = 1'b0;
    end
`endif
  end

  always_ff @(posedge ispi_clk) begin
    if (ireset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_csn_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_csn_fall)  w_state_nxt = S_ADDR;
        S_ADDR:    if (w_byte_done) w_state_nxt = w_shift_next[7] ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA: if (w_byte_done) w_state_nxt = S_WR_IGNORE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    oBUSY    = (r_state != S_IDLE);
    oSPI_SDO = 1'b1;
    if (r_state == S_RD_DATA) oSPI_SDO = r_sdo;
  end

  assign oREG_WR    = r_reg_wr;
  assign oREG_ADDR  = r_reg_addr;
  assign oREG_WDATA = r_reg_wdata;
  assign oFRAME_END = r_frame_end;

  always_ff @(posedge ispi_clk) begin
    if (ireset) begin
      {r_sclk_s1, r_sclk_s2, r_sclk_s3} <= 3'b111;
      {r_csn_s1, r_csn_s2, r_csn_s3}    <= 3'b111;
      {r_sdi_s1, r_sdi_s2}              <= 2'b11;
      r_shift     <= '0;
      r_tx        <= '0;
      r_bitcnt    <= 3'd7;
      r_addr      <= '0;
      r_sdo       <= 1'b1;
      r_snap_x    <= '0;
      r_snap_y    <= '0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_frame_end <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) r_regs[i] <= '0;
    end else begin
      {r_sclk_s1, r_sclk_s2, r_sclk_s3} <= {iSPI_CLK, r_sclk_s1, r_sclk_s2};
      {r_csn_s1, r_csn_s2, r_csn_s3}    <= {iSPI_CSN, r_csn_s1, r_csn_s2};
      {r_sdi_s1, r_sdi_s2}              <= {iSPI_SDI, r_sdi_s1};
      r_reg_wr    <= 1'b0;
      r_frame_end <= w_csn_rise;
      // Snapshot freezes for the whole frame so a burst read is coherent
      if (iDATA_VALID && !oBUSY) begin
        r_snap_x <= iDATA_X;
        r_snap_y <= iDATA_Y;
      end
      if (w_csn_rise) begin
        r_bitcnt <= 3'd7;
        r_sdo    <= 1'b1;
      end else begin
        case (r_state)
          S_ADDR: if (w_sclk_rise) begin
            r_shift  <= w_shift_next[6:0];
            r_bitcnt <= r_bitcnt - 3'd1;
            if (r_bitcnt == 3'd0) begin
              r_addr <= w_shift_next[ADDR_W-1:0];
              r_sdo  <= 1'b1;
            end
          end
          S_WR_DATA: if (w_sclk_rise) begin
            r_shift  <= w_shift_next[6:0];
            r_bitcnt <= r_bitcnt - 3'd1;
            if (r_bitcnt == 3'd0 && w_wr_ok) begin
              r_regs[r_addr] <= w_shift_next;
              r_reg_wr       <= 1'b1;
              r_reg_addr     <= r_addr;
              r_reg_wdata    <= w_shift_next;
            end
          end
          // Count 7 loads a fresh byte; count 0 drives the LSB and advances the address
          S_RD_DATA: if (w_sclk_fall) begin
            r_bitcnt <= r_bitcnt - 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_sdo <= w_rd_byte[7];
              r_tx  <= {w_rd_byte[6:0], 1'b0};
            end else begin
              r_sdo <= r_tx[7];
              r_tx  <= {r_tx[6:0], 1'b0};
            end
            if (r_bitcnt == 3'd0) r_addr <= r_addr + ADDR_W'(1);
          end
          default: r_bitcnt <= 3'd7;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench for spi_sensor_responder acting as the SPI initiator; expectations follow SPI_RSP_DEVID_EN.
// SCLK half period is 8 system clocks, well above the 3-cycle synchronizer latency.
module tb_spi_sensor_responder;

  logic        ispi_clk = 1'b0;
  logic        ireset;
  logic        iSPI_CLK, iSPI_CSN, iSPI_SDI;
  logic        oSPI_SDO;
  logic [15:0] iDATA_X, iDATA_Y;
  logic        iDATA_VALID;
  logic        oREG_WR;
  logic [5:0]  oREG_ADDR;
  logic [7:0]  oREG_WDATA;
  logic        oFRAME_END, oBUSY;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          fe_cnt = 0;
  logic [5:0]  last_addr;
  logic [7:0]  last_data;

  spi_sensor_responder dut (
    .ispi_clk    (ispi_clk),
    .ireset      (ireset),
    .iSPI_CLK    (iSPI_CLK),
    .iSPI_CSN    (iSPI_CSN),
    .iSPI_SDI    (iSPI_SDI),
    .oSPI_SDO    (oSPI_SDO),
    .iDATA_X     (iDATA_X),
    .iDATA_Y     (iDATA_Y),
    .iDATA_VALID (iDATA_VALID),
    .oREG_WR     (oREG_WR),
    .oREG_ADDR   (oREG_ADDR),
    .oREG_WDATA  (oREG_WDATA),
    .oFRAME_END  (oFRAME_END),
    .oBUSY       (oBUSY)
  );

  always #5 ispi_clk = ~ispi_clk;

  always @(negedge ispi_clk) begin
    if (oREG_WR) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = oREG_ADDR;
      last_data = oREG_WDATA;
    end
    if (oFRAME_END) fe_cnt = fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge ispi_clk);
  endtask

  task automatic spi_start;
    wait_clk(1);
    iSPI_CSN = 1'b0;
    wait_clk(8);
  endtask

  task automatic spi_stop;
    wait_clk(8);
    iSPI_CSN = 1'b1;
    wait_clk(8);
  endtask

  // Shifts n bits of tx MSB-first; rx collects SDO sampled just before each rise
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      iSPI_CLK = 1'b0;
      iSPI_SDI = tx[7-i];
      wait_clk(8);
      rx = {rx[6:0], oSPI_SDO};
      iSPI_CLK = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    spi_start;
    spi_bits(a, 8, dummy);
    spi_bits(d, 8, dummy);
    spi_stop;
  endtask

  task automatic reg_read1(input logic [7:0] a, output logic [7:0] d);
    logic [7:0] dummy;
    spi_start;
    spi_bits(a, 8, dummy);
    spi_bits(8'hFF, 8, d);
    spi_stop;
  endtask

  task automatic pulse_valid(input logic [15:0] x, input logic [15:0] y);
    iDATA_X = x;
    iDATA_Y = y;
    wait_clk(1);
    iDATA_VALID = 1'b1;
    wait_clk(1);
    iDATA_VALID = 1'b0;
    wait_clk(1);
  endtask

  logic [7:0] rd, dummy;
  int         wr0, fe0;

  initial begin
    ireset = 1'b1;
    iSPI_CLK = 1'b1;
    iSPI_CSN = 1'b1;
    iSPI_SDI = 1'b1;
    iDATA_X = '0;
    iDATA_Y = '0;
    iDATA_VALID = 1'b0;
    wait_clk(5);
    check("rst_sdo", oSPI_SDO, 1);
    check("rst_wr", oREG_WR, 0);
    check("rst_addr", oREG_ADDR, 0);
    check("rst_wdata", oREG_WDATA, 0);
    check("rst_fe", oFRAME_END, 0);
    check("rst_busy", oBUSY, 0);
    ireset = 1'b0;
    wait_clk(4);

    // Write 0x2D=0x08 then read it back
    wr0 = wr_cnt; fe0 = fe_cnt;
    reg_write(8'h2D, 8'h08);
    check("t1_wr_cnt", wr_cnt - wr0, 1);
    check("t1_addr", last_addr, 6'h2D);
    check("t1_data", last_data, 8'h08);
    check("t1_fe_cnt", fe_cnt - fe0, 1);
    reg_read1(8'hAD, rd);
    check("t1_rd", rd, 8'h08);

    // Snapshot burst read
    pulse_valid(16'h1234, 16'hABCD);
    fe0 = fe_cnt;
    spi_start;
    check("t2_busy", oBUSY, 1);
    spi_bits(8'hB2, 8, dummy);
    spi_bits(8'hFF, 8, rd); check("t2_x0", rd, 8'h34);
    spi_bits(8'hFF, 8, rd); check("t2_x1", rd, 8'h12);
    spi_bits(8'hFF, 8, rd); check("t2_y0", rd, 8'hCD);
    spi_bits(8'hFF, 8, rd); check("t2_y1", rd, 8'hAB);
    spi_stop;
    check("t2_fe_cnt", fe_cnt - fe0, 1);
    check("t2_idle", oBUSY, 0);
    check("t2_sdo_idle", oSPI_SDO, 1);

    // Aborted write after 5 data bits
    wr0 = wr_cnt; fe0 = fe_cnt;
    spi_start;
    spi_bits(8'h10, 8, dummy);
    spi_bits(8'hFF, 5, dummy);
    spi_stop;
    check("t3_wr_cnt", wr_cnt - wr0, 0);
    check("t3_fe_cnt", fe_cnt - fe0, 1);
    reg_read1(8'h90, rd);
    check("t3_rd", rd, 8'h00);

    // Writes into the sample window are dropped
    wr0 = wr_cnt;
    reg_write(8'h33, 8'h99);
    check("win_wr_cnt", wr_cnt - wr0, 0);
    reg_read1(8'hB3, rd);
    check("win_rd", rd, 8'h12);

    // Address wrap 0x3F -> 0x00
    reg_write(8'h3F, 8'h5A);
    reg_write(8'h00, 8'h11);
    spi_start;
    spi_bits(8'hBF, 8, dummy);
    spi_bits(8'hFF, 8, rd); check("t4_b0", rd, 8'h5A);
    spi_bits(8'hFF, 8, rd);
`ifdef SPI_RSP_DEVID_EN
    check("t4_b1", rd, 8'hE5);
`else
    check("t4_b1", rd, 8'h11);
`endif
    spi_stop;

    // VALID during a frame is dropped; next VALID between frames takes effect
    pulse_valid(16'h1111, 16'h2222);
    spi_start;
    spi_bits(8'hB2, 8, dummy);
    pulse_valid(16'h5555, 16'h6666);
    spi_bits(8'hFF, 8, rd); check("t5_x0", rd, 8'h11);
    spi_bits(8'hFF, 8, rd); check("t5_x1", rd, 8'h11);
    spi_bits(8'hFF, 8, rd); check("t5_y0", rd, 8'h22);
    spi_bits(8'hFF, 8, rd); check("t5_y1", rd, 8'h22);
    spi_stop;
    pulse_valid(16'h5555, 16'h6666);
    spi_start;
    spi_bits(8'hB2, 8, dummy);
    spi_bits(8'hFF, 8, rd); check("t5n_x0", rd, 8'h55);
    spi_bits(8'hFF, 8, rd); check("t5n_x1", rd, 8'h55);
    spi_bits(8'hFF, 8, rd); check("t5n_y0", rd, 8'h66);
    spi_bits(8'hFF, 8, rd); check("t5n_y1", rd, 8'h66);
    spi_stop;

    // Address 0 behaviour depends on the DEVID option
    wr0 = wr_cnt;
    reg_write(8'h00, 8'h77);
    reg_read1(8'h80, rd);
`ifdef SPI_RSP_DEVID_EN
    check("t6_wr_cnt", wr_cnt - wr0, 0);
    check("t6_rd", rd, 8'hE5);
`else
    check("t6_wr_cnt", wr_cnt - wr0, 1);
    check("t6_rd", rd, 8'h77);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
